// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Readback monitor for a multiplexed, active-low seven-segment display bus.
//   Recovers the hex value shown on each digit once the (segment, select)
//   pattern has been stable for STABLE_CYCLES synchronized samples.
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   seg_in[6:0]      segment lines, active-low, bit0=a .. bit6=g
//   dig_sel_n[N-1:0] digit selects, active-low; exactly one low = scan slot
//   digits_out       captured hex values, digit i at [4i+3:4i]
//   digit_valid      1 = digit i holds a decoded hex value
//   update           one-cycle pulse on every capture (hex, blank or invalid)
//   update_idx       digit index of the most recent capture
//   invalid_pattern  one-cycle pulse with update when the pattern is unknown
//
// Handshake: there is no back-pressure. update is a single-cycle strobe;
// digits_out/digit_valid/update_idx are already updated on the cycle the
// strobe is high and hold until the next capture.

module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic [IDX_W-1:0]        update_idx,
  output logic                    invalid_pattern
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [6:0]            seg_s1, seg_s2, seg_prev;
  logic [NUM_DIGITS-1:0] sel_s1, sel_s2, sel_prev;
  logic [3:0]            cnt, cnt_next;

  logic                  changed;
  logic                  one_hot;
  logic [IDX_W:0]        zero_cnt;
  logic [IDX_W-1:0]      sel_idx;
  logic                  capture;
  logic [3:0]            hex_val;
  logic                  is_hex;
  logic                  is_blank;

  // Two-flop synchronizers plus the previous-cycle copy of the synced pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
      sel_s1   <= '1;
      sel_s2   <= '1;
      sel_prev <= '1;
      cnt      <= '0;
      state    <= EMPTY;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      sel_s1   <= dig_sel_n;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
      cnt      <= cnt_next;
      state    <= state_next;
    end
  end

  // A segment change and a select change in the same cycle are one change.
  assign changed = (seg_s2 != seg_prev) || (sel_s2 != sel_prev);

  always_comb begin
    cnt_next = 4'd1;
    if (!changed) begin
      cnt_next = (cnt >= STABLE) ? STABLE : cnt + 4'd1;
    end
  end

  // Count low selects and remember which one is low.
  always_comb begin
    zero_cnt = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel_s2[i]) begin
        zero_cnt = zero_cnt + {{IDX_W{1'b0}}, 1'b1};
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign one_hot = (zero_cnt == {{IDX_W{1'b0}}, 1'b1});

  // The count saturates, so HELD must be excluded explicitly until S moves.
  assign capture = one_hot && (cnt_next == STABLE) && ((state != HELD) || changed);

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (one_hot) state_next = capture ? HELD : TRACK;
      end
      TRACK: begin
        if (!one_hot)    state_next = EMPTY;
        else if (capture) state_next = HELD;
        else              state_next = TRACK;
      end
      HELD: begin
        if (changed) begin
          if (!one_hot)     state_next = EMPTY;
          else if (capture) state_next = HELD;
          else              state_next = TRACK;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Segment code (g..a, active-low) to hex value.
  always_comb begin
    hex_val  = 4'h0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    case (seg_s2)
      7'h40: hex_val = 4'h0;
      7'h79: hex_val = 4'h1;
      7'h24: hex_val = 4'h2;
      7'h30: hex_val = 4'h3;
      7'h19: hex_val = 4'h4;
      7'h12: hex_val = 4'h5;
      7'h02: hex_val = 4'h6;
      7'h78: hex_val = 4'h7;
      7'h00: hex_val = 4'h8;
      7'h10: hex_val = 4'h9;
      7'h08: hex_val = 4'hA;
      7'h03: hex_val = 4'hB;
      7'h46: hex_val = 4'hC;
      7'h21: hex_val = 4'hD;
      7'h06: hex_val = 4'hE;
      7'h0E: hex_val = 4'hF;
      7'h7F: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default: is_hex = 1'b0;
    endcase
  end

  // Blank and invalid captures clear the valid flag but keep the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_out      <= '0;
      digit_valid     <= '0;
      update          <= 1'b0;
      update_idx      <= '0;
      invalid_pattern <= 1'b0;
    end else begin
      update          <= capture;
      invalid_pattern <= capture && !is_hex && !is_blank;
      if (capture) update_idx <= sel_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && (sel_idx == IDX_W'(i))) begin
          digit_valid[i] <= is_hex;
          if (is_hex) digits_out[4*i +: 4] <= hex_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Randomized plus directed bench for seg_scan_decoder. A reference model
//   predicts the full output set for every clock edge and pushes it into a
//   queue; a monitor pops one entry per edge and compares.

module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 3;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [6:0]      seg_in;
  logic [ND-1:0]   dig_sel_n;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0]   digit_valid;
  logic            update;
  logic [IW-1:0]   update_idx;
  logic            invalid_pattern;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .seg_in          (seg_in),
    .dig_sel_n       (dig_sel_n),
    .digits_out      (digits_out),
    .digit_valid     (digit_valid),
    .update          (update),
    .update_idx      (update_idx),
    .invalid_pattern (invalid_pattern)
  );

  typedef struct packed {
    logic            upd;
    logic            inv;
    logic [IW-1:0]   idx;
    logic [4*ND-1:0] digs;
    logic [ND-1:0]   val;
  } out_t;

  out_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // ---------------- reference model ----------------
  // Pins driven before edge k reach the logic as S at edge k+2; a capture
  // happens on the edge where a run of identical S with one low select
  // reaches exactly SC samples long.
  logic [10:0] pin_q[$];
  logic [10:0] last_s;
  int          run;
  out_t        m;

  task automatic model_reset();
    pin_q  = '{11'h7FF, 11'h7FF};
    last_s = 11'h7FF;
    run    = 0;
    m      = '0;
  endtask

  task automatic model_edge(input logic [10:0] p);
    logic [10:0] s;
    int zeros, pos, hv;
    s = pin_q.pop_front();
    pin_q.push_back(p);
    if (s == last_s) run++;
    else run = 1;
    last_s = s;
    m.upd = 1'b0;
    m.inv = 1'b0;
    zeros = 0;
    pos   = 0;
    for (int i = 0; i < ND; i++) begin
      if (!s[7+i]) begin
        zeros++;
        pos = i;
      end
    end
    if (zeros == 1 && run == SC) begin
      m.upd = 1'b1;
      m.idx = IW'(pos);
      hv = -1;
      for (int v = 0; v < 16; v++) if (hex_tbl[v] == s[6:0]) hv = v;
      if (hv >= 0) begin
        m.digs[4*pos +: 4] = 4'(hv);
        m.val[pos] = 1'b1;
      end else begin
        m.val[pos] = 1'b0;
        if (s[6:0] != 7'h7F) m.inv = 1'b1;
      end
    end
    exp_q.push_back(m);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [6:0] seg, input logic [ND-1:0] sel, input int n);
    for (int k = 0; k < n; k++) begin
      reset_n   = 1'b1;
      seg_in    = seg;
      dig_sel_n = sel;
      model_edge({sel, seg});
      @(negedge clk);
    end
  endtask

  // Reset held for one clock edge; outputs must clear without waiting for it.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("reset_outputs",
          64'({update, invalid_pattern, update_idx, digits_out, digit_valid}), 64'd0);
    model_reset();
    exp_q.push_back(m);
    @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    out_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (!done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL queue_underflow actual=empty expected=entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("edge_outputs",
                64'({update, invalid_pattern, update_idx, digits_out, digit_valid}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int hold;
    logic [ND-1:0] rsel;
    logic [6:0]    rseg;
    reset_n   = 1'b1;
    seg_in    = 7'h7F;
    dig_sel_n = '1;
    #2;
    do_reset();

    // single digit, long hold
    drive(7'h24, 4'b1110, 10);
    check("t1_digit0", 64'(digits_out[3:0]), 64'h2);
    check("t1_valid", 64'(digit_valid), 64'b0001);

    // full scan
    drive(7'h79, 4'b1110, 6);
    drive(7'h30, 4'b1101, 6);
    drive(7'h12, 4'b1011, 6);
    drive(7'h0E, 4'b0111, 6);
    check("t2_digits", 64'(digits_out), 64'hF531);
    check("t2_valid", 64'(digit_valid), 64'hF);

    // short glitch then a stable 8
    drive(7'h40, 4'b1101, 2);
    drive(7'h00, 4'b1101, 6);
    check("t3_digit1", 64'(digits_out[7:4]), 64'h8);

    // blank then invalid on digit 2
    drive(7'h7F, 4'b1011, 6);
    check("t4_blank_valid", 64'(digit_valid[2]), 64'd0);
    check("t4_blank_value", 64'(digits_out[11:8]), 64'h5);
    drive(7'h55, 4'b1011, 6);
    check("t4_invalid_valid", 64'(digit_valid[2]), 64'd0);

    // select not one-hot
    drive(7'h79, 4'b1100, 20);
    drive(7'h79, 4'b1111, 20);
    check("t5_digits", 64'(digits_out), 64'hF581);
    check("t5_valid", 64'(digit_valid), 64'b1011);

    // reset in the middle of a count
    drive(7'h02, 4'b0111, 4);
    do_reset();
    drive(7'h02, 4'b0111, 8);
    check("t6_digits", 64'(digits_out), 64'h6000);
    check("t6_valid", 64'(digit_valid), 64'b1000);

    // randomized scan traffic
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: rsel = ~(ND'(1) << $urandom_range(0, ND - 1));
        7:       rsel = '1;
        default: rsel = ND'($urandom_range(0, (1 << ND) - 1));
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rseg = hex_tbl[$urandom_range(0, 15)];
        6:       rseg = 7'h7F;
        default: rseg = 7'($urandom_range(0, 127));
      endcase
      hold = $urandom_range(1, 6);
      if ($urandom_range(0, 39) == 0) do_reset();
      drive(rseg, rsel, hold);
    end
    drive(7'h7F, 4'b1111, 6);

    done = 1'b1;
    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
